// File: rtl/keypad_decoder.sv
// keypad_decoder: receive side of a 4x4 keypad scan.
// Aligns raw rows with the scanner's column strobe, builds one scan frame
// per column sweep and debounces frame results into key press/release events.
module keypad_decoder #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic [3:0] column,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] LP_N = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Saturating 4-bit increment; counters never wrap.
    function automatic logic [3:0] sat_inc(input logic [3:0] x);
        return (x == 4'hF) ? 4'hF : x + 4'd1;
    endfunction

    logic [3:0] r_row_s1, r_row_s2;
    logic [3:0] r_col_d1, r_col_d2;

    // Frame accumulator state
    logic       r_open;
    logic [3:0] r_hits;
    logic [3:0] r_code;
    logic       r_multi;

    // Debounce state
    state_t     r_state;
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_rel_cnt;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_key_held;

    // Row is asynchronous: two-stage synchronizer. Column gets the same
    // two-cycle delay so each synced row pairs with the column that lit it.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= 4'd0;
            r_row_s2 <= 4'd0;
            r_col_d1 <= 4'd0;
            r_col_d2 <= 4'd0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            r_col_d1 <= column;
            r_col_d2 <= r_col_d1;
        end
    end

    logic       w_col_oh, w_row_none, w_row_oh;
    logic [1:0] w_col_idx, w_row_idx;
    logic       w_first, w_last, w_in_frame, w_close;
    logic       w_hit, w_mul;
    logic [3:0] w_hits_base, w_code_base;
    logic       w_multi_base;
    logic [3:0] w_hits_nx, w_code_nx;
    logic       w_multi_nx;
    logic       w_single;

    // Classify the aligned sample and fold it into the running frame.
    always_comb begin
        w_col_oh   = 1'b1;
        w_col_idx  = 2'd0;
        case (r_col_d2)
            4'b0001: w_col_idx = 2'd0;
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_oh  = 1'b0;
        endcase

        w_row_oh   = 1'b1;
        w_row_idx  = 2'd0;
        case (r_row_s2)
            4'b0001: w_row_idx = 2'd0;
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_oh  = 1'b0;
        endcase
        w_row_none = (r_row_s2 == 4'd0);

        w_first    = (r_col_d2 == 4'b0001);
        w_last     = (r_col_d2 == 4'b1000);
        // A frame only exists once a 0001 sample has opened it.
        w_in_frame = w_first || r_open;
        w_close    = w_last && w_in_frame;

        w_hit = w_col_oh && w_row_oh;
        w_mul = w_col_oh && !w_row_none && !w_row_oh;

        w_hits_base  = w_first ? 4'd0 : r_hits;
        w_code_base  = w_first ? 4'd0 : r_code;
        w_multi_base = w_first ? 1'b0 : r_multi;

        w_hits_nx  = w_hit ? sat_inc(w_hits_base) : w_hits_base;
        w_code_nx  = w_hit ? {w_col_idx, w_row_idx} : w_code_base;
        w_multi_nx = w_multi_base || w_mul;

        // Multi-key frames count as empty (ghosting rejection).
        w_single = w_close && (w_hits_nx == 4'd1) && !w_multi_nx;
    end

    // Frame accumulator: opened at column 0001, released at column 1000.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_open  <= 1'b0;
            r_hits  <= 4'd0;
            r_code  <= 4'd0;
            r_multi <= 1'b0;
        end else if (w_close) begin
            r_open  <= 1'b0;
            r_hits  <= 4'd0;
            r_code  <= 4'd0;
            r_multi <= 1'b0;
        end else if (w_in_frame) begin
            r_open  <= 1'b1;
            r_hits  <= w_hits_nx;
            r_code  <= w_code_nx;
            r_multi <= w_multi_nx;
        end
    end

    // Debounce FSM, stepped once per closed frame, with registered outputs.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= 4'd0;
            r_rel_cnt   <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_close) begin
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_cand  <= w_code_nx;
                            r_cnt   <= 4'd1;
                            r_state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_single && (w_code_nx == r_cand)) begin
                            if (sat_inc(r_cnt) == LP_N) begin
                                r_state     <= PRESSED;
                                r_cnt       <= 4'd0;
                                r_rel_cnt   <= 4'd0;
                                r_key_code  <= r_cand;
                                r_key_held  <= 1'b1;
                                r_key_valid <= 1'b1;
                            end else begin
                                r_cnt <= sat_inc(r_cnt);
                            end
                        end else if (w_single) begin
                            r_cand <= w_code_nx;
                            r_cnt  <= 4'd1;
                        end else begin
                            r_cnt   <= 4'd0;
                            r_state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (w_single && (w_code_nx == r_cand)) begin
                            r_rel_cnt <= 4'd0;
                        end else if (sat_inc(r_rel_cnt) == LP_N) begin
                            r_rel_cnt  <= 4'd0;
                            r_cnt      <= 4'd0;
                            r_key_held <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_rel_cnt <= sat_inc(r_rel_cnt);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: plays the column scanner and keypad, and checks every
// cycle against a frame-level run-length model of press/release debouncing.
module tb_keypad_decoder;
    localparam int N = 4;

    logic       clk_1 = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] column = 4'd0;
    logic [3:0] row = 4'd0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_decoder #(.DEBOUNCE_SCANS(N)) dut (
        .clk_1(clk_1), .rst_n(rst_n), .column(column), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk_1 = ~clk_1;

    int tests = 0;
    int fails = 0;

    // Model: run of identical single-key frames while not held, run of
    // non-matching frames while held.
    int         run, run_key, rel;
    logic       m_held;
    logic [3:0] m_code;
    // Expected outputs per scan cycle; outputs lag the driven column by 3.
    logic       h_v [4];
    logic       h_h [4];
    logic [3:0] h_c [4];
    int         it;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, it);
        end
    endtask

    task automatic model_reset();
        run = 0; run_key = -1; rel = 0; m_held = 1'b0; m_code = 4'd0; it = 0;
        for (int i = 0; i < 4; i++) begin
            h_v[i] = 1'b0; h_h[i] = 1'b0; h_c[i] = 4'd0;
        end
    endtask

    task automatic model_close(input logic [15:0] mask, output logic pulse);
        int k, pc;
        pulse = 1'b0;
        pc = $countones(mask);
        k = -1;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        if (!m_held) begin
            if (pc == 1 && run > 0 && k == run_key) run++;
            else if (pc == 1) begin run_key = k; run = 1; end
            else run = 0;
            if (run == N) begin
                pulse = 1'b1; m_held = 1'b1; m_code = 4'(k); run = 0; rel = 0;
            end
        end else begin
            if (pc == 1 && k == int'(m_code)) rel = 0;
            else rel++;
            if (rel == N) begin m_held = 1'b0; rel = 0; run = 0; end
        end
    endtask

    task automatic do_cycle(input logic [15:0] mask, input int c);
        int   idx;
        logic pulse;
        @(negedge clk_1);
        idx = (it + 1) % 4;
        check("key_valid", {3'd0, key_valid}, {3'd0, h_v[idx]});
        check("key_held",  {3'd0, key_held},  {3'd0, h_h[idx]});
        check("key_code",  key_code, h_c[idx]);
        column = 4'b0001 << c;
        row    = mask[c*4 +: 4];
        pulse  = 1'b0;
        if (c == 3) model_close(mask, pulse);
        h_v[it % 4] = pulse;
        h_h[it % 4] = m_held;
        h_c[it % 4] = m_code;
        it++;
    endtask

    task automatic frames(input logic [15:0] mask, input int n);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < 4; c++) do_cycle(mask, c);
    endtask

    function automatic logic [15:0] key(input int k);
        logic [15:0] one;
        one = 16'd1;
        return one << k;
    endfunction

    initial begin
        logic [15:0] cur;
        int          sel;
        model_reset();
        #12;
        check("rst_code",  key_code, 4'd0);
        check("rst_valid", {3'd0, key_valid}, 4'd0);
        check("rst_held",  {3'd0, key_held}, 4'd0);
        @(negedge clk_1);
        rst_n = 1'b1;

        // Clean press of key 9, then release
        frames(key(9), 4);
        frames(16'd0, 5);
        // Bounce: present, present, absent, then stable
        frames(key(9), 2);
        frames(16'd0, 1);
        frames(key(9), 4);
        frames(16'd0, 5);
        // Key change mid-debounce
        frames(key(0), 2);
        frames(key(15), 4);
        frames(16'd0, 5);
        // Ghosting: keys 1 and 6 together
        frames(key(1) | key(6), 8);
        frames(16'd0, 1);
        // Release glitch on key 5
        frames(key(5), 4);
        frames(16'd0, 2);
        frames(key(5), 1);
        frames(16'd0, 5);
        // Different key while held must wait for release
        frames(key(7), 4);
        frames(key(2), 8);
        frames(16'd0, 5);

        // Randomized frames: mostly held keys with drops, switches, ghosts
        cur = key(int'($urandom_range(0, 15)));
        for (int f = 0; f < 120; f++) begin
            sel = int'($urandom_range(0, 11));
            if (sel <= 1)      frames(16'd0, 1);
            else if (sel <= 8) frames(cur, 1);
            else if (sel == 9) begin
                cur = key(int'($urandom_range(0, 15)));
                frames(cur, 1);
            end else if (sel == 10)
                frames(cur | key(int'($urandom_range(0, 15))), 1);
            else
                frames(16'd0, int'($urandom_range(4, 6)));
        end
        frames(16'd0, 6);

        // Asynchronous reset in the middle of a frame while a key is held
        frames(key(3), 5);
        do_cycle(key(3), 0);
        do_cycle(key(3), 1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_code",  key_code, 4'd0);
        check("midrst_valid", {3'd0, key_valid}, 4'd0);
        check("midrst_held",  {3'd0, key_held}, 4'd0);
        @(negedge clk_1);
        rst_n = 1'b1;
        model_reset();
        frames(key(3), 3);
        frames(key(3), 1);
        frames(16'd0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the bench itself stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
